regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port integer register file for the nebula core, the successor to the fixed two-read-port regfile. It provides NREAD registered read ports and one write port with configurable write-to-read bypass. Register 0 is hard-wired to zero. After reset, an internal sequencer clears every architectural register before asserting `ready_o`, so the storage can map to RAM without a per-flop reset.

## Interface
- `XLEN`, default 32: register width in bits.
- `NREGS`, default 32: number of architectural registers. Must be a power of two and at least 2.
- `NREAD`, default 2: number of read ports. Must be at least 1.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to matching reads. When 0, reads return the pre-write value.
- `AW`: derived, equal to `$clog2(NREGS)`. Not overridable.
- `clk_i` — input — 1 — the single clock. All logic is rising-edge.
- `rst_i` — input — 1 — synchronous, active-high reset.
- `ready_o` — output — 1 — high when the clear sequence is complete and the file accepts reads and writes.
- `rd_en_i` — input — 1 — read enable. When low, all `rdata_o` ports hold their values (pipeline stall).
- `raddr_i` — input — NREAD×AW — read addresses, one per port.
- `rdata_o` — output — NREAD×XLEN — registered read data, one per port.
- `we_i` — input — 1 — write enable.
- `waddr_i` — input — AW — write address.
- `wdata_i` — input — XLEN — write data.

## Operation
- **Storage:** entries 1..NREGS-1, each XLEN bits. Entry 0 is not stored. A read of address 0 always returns 0. A write to address 0 is discarded.
- **FSM states:** CLEAR and RUN. A clear counter `cnt` (AW bits) tracks progress.
- **Reset:** `rst_i`=1 at an edge sets state to CLEAR, `cnt` to 1, `ready_o` to 0, and all `rdata_o` to 0. Stored entries are not touched on reset edges.
- **CLEAR:** each edge with `rst_i`=0 writes 0 to entry `cnt` and increments `cnt`.
  - At the edge that clears entry NREGS-1, state moves to RUN and `ready_o` is set to 1.
  - While in CLEAR, `we_i` and `rd_en_i` are ignored and `rdata_o` holds 0.
- **RUN, write:** `we_i`=1 with `waddr_i`≠0 writes `wdata_i` into entry `waddr_i` at the edge.
- **RUN, read:** `rd_en_i`=1 at an edge loads each `rdata_o[p]` as follows:
  - `raddr_i[p]`=0 gives 0.
  - Otherwise, if `BYPASS`=1, `we_i`=1 and `waddr_i`==`raddr_i[p]`, it gives `wdata_i`.
  - Otherwise it gives the stored entry value before this edge's write.
- **Stall:** `rd_en_i`=0 in RUN leaves every `rdata_o` unchanged, even when a write updates the entry being displayed. Writes still complete during a stall.
- **Port independence:** read ports are fully independent. Any number of ports may name the same address.
- **Reset mid-CLEAR:** the sequence restarts with `cnt`=1, and `ready_o` stays 0.
- **Reset in RUN:** contents are re-cleared by the new sequence. No prior value is observable after `ready_o` rises.
- **Zero-register check:** a simulation-only assertion fires `$fatal` if any `rdata_o[p]` is nonzero on the cycle after a read of address 0.

## Timing
- **Reset values:** `ready_o`=0 and `rdata_o[*]`=0.
- **Clear duration:** the clear takes NREGS-1 edges with `rst_i`=0. `ready_o` is 1 after the (NREGS-1)th such edge, which is edge 31 for the default NREGS.
- **Read latency:** 1 cycle. An address presented before edge k produces data that is valid after edge k.
- **Write visibility:**
  - Write at edge k, read issued at edge k+1 or later: returns the new value with any `BYPASS` setting.
  - Same-edge write and read to the same address: returns the new value only when `BYPASS`=1.
- **Held inputs:** `we_i` and `rd_en_i` have no effect while `ready_o`=0. No handshake is needed beyond `ready_o`.

## Test plan
- **Reset/clear:** hold `rst_i`=1 for 3 cycles, then release. Required: `ready_o`=0 for exactly 31 edges and 1 after the 31st. Reads of addresses 0..31 then all return 0.
- **Write/read:** write 0xDEADBEEF to x5 at edge k, then read x5 on port 0 and x0 on port 1 at edge k+1. Required: port 0 = 0xDEADBEEF and port 1 = 0.
- **Bypass:** with `BYPASS`=1, x7 holds 0x11. Write 0x22 to x7 while reading x7 on both ports in the same cycle. Required: both ports = 0x22. Repeat with `BYPASS`=0: required both ports = 0x11, then 0x22 on the next read.
- **x0 discard and stall:**
  - Write 0xFFFF to x0, then read x0. Required: 0.
  - Read x3 (0x33), drop `rd_en_i`, then write 0x44 to x3. Required: `rdata_o` stays 0x33 until `rd_en_i` returns, then shows 0x44.
- **Reset mid-clear:** assert `rst_i` for 1 cycle at clear edge 10. Required: `ready_o` rises 31 edges after the new release, not earlier.
- **Configuration:** run NREAD=3, NREGS=16, XLEN=64. Write distinct values to x1..x15 and read three different addresses per cycle. Required: every port matches the reference model every cycle, and `ready_o` rises after 15 clear edges.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-to-read bypass and a
// post-reset clear sequencer so the storage array needs no per-entry reset.
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | zeroing entries 1..NREGS-1, one per edge; reads/writes ignored
// RUN   | normal operation, ready_o high
module regfile_mp #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  NREAD  = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  rd_en_i,
    input  logic [NREAD*AW-1:0]   raddr_i,
    output logic [NREAD*XLEN-1:0] rdata_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [XLEN-1:0]       wdata_i
);

    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be a power of two and at least 2");
    end
    if (NREAD < 1) begin : g_bad_nread
        $error("regfile_mp: NREAD must be at least 1");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            rd_load;

    // Entry 0 is never stored; address 0 is decoded away on both sides.
    logic [XLEN-1:0] mem [1:NREGS-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        rd_load   = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we  = we_i && (waddr_i != '0);
                rd_load = rd_en_i;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = AW'(1);
            end
        endcase
    end

    assign ready_o = (state_q == RUN);

    // Reset edges must not disturb storage; the clear pass owns re-initialisation.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd_nxt;
        logic [XLEN-1:0] rdata_q;

        assign ra = raddr_i[p*AW +: AW];

        always_comb begin
            rd_nxt = '0;
            if (ra != '0) begin
                if (BYPASS != 0 && we_i && waddr_i == ra) begin
                    rd_nxt = wdata_i;
                end else begin
                    rd_nxt = mem[ra];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (rd_load) begin
                rdata_q <= rd_nxt;
            end
        end

        assign rdata_o[p*XLEN +: XLEN] = rdata_q;

        zero_reg_check: assert property (
            @(posedge clk_i) disable iff (rst_i)
            (rd_load && ra == '0) |=> (rdata_o[p*XLEN +: XLEN] == '0)
        ) else $fatal(1, "regfile_mp: port %0d returned nonzero for x0", p);
    end

endmodule
